stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control unit for the running-watch datapath. It debounces the start/stop, lap and clear buttons and runs the watch state machine. It generates the 100 Hz count tick and synchronous clear that drive the cascaded mod-N counter chain. It also provides the display value, which is either live or frozen for a lap.

## Interface
- CLK_DIV, 100000, tick prescale ratio (10 MHz clk -> 100 Hz tick); must be >= 2
- DEB_CYCLES, 200000, consecutive stable samples needed to accept a button level (20 ms); must be >= 1
- DIGITS, 6, number of BCD digits in the counter chain
- clk  input  1  system clock, 10 MHz
- rst_n  input  1  asynchronous, active-low reset
- btn_start  input  1  raw start/stop button, active high, asynchronous to clk
- btn_lap  input  1  raw lap button, active high, asynchronous
- btn_clr  input  1  raw clear button, active high, asynchronous
- cnt_value  input  4*DIGITS  live BCD value of the counter chain
- cnt_carry_top  input  1  full pulse from the most significant counter
- cnt_tick  output  1  one-cycle count enable into the least significant counter
- cnt_clear  output  1  one-cycle synchronous clear to all counters
- disp_value  output  4*DIGITS  value to display
- running  output  1  high in RUN or LAP
- lap_active  output  1  high in LAP
- overflow  output  1  sticky flag, set when the counter chain wraps

## Operation
- **Button front end.** Each button goes through a 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after DEB_CYCLES consecutive samples that differ from the current level.
  - A press event is a one-cycle pulse on the debounced rising edge. Releases generate no event.
- **Event priority.** When events coincide in the same cycle, the order is clr > start > lap. Only the winning event is acted on, and the others are dropped.
- **States.** IDLE, RUN, LAP and PAUSE. The reset state is IDLE.
- **Transitions from IDLE:**
  - start -> RUN
  - clr -> IDLE, with a cnt_clear pulse
  - lap is ignored
- **Transitions from RUN:**
  - start -> PAUSE
  - lap -> LAP, latching cnt_value into the lap register
  - clr is ignored
- **Transitions from LAP:**
  - lap -> RUN
  - start -> PAUSE, with the display returning to the live value
  - clr is ignored
- **Transitions from PAUSE:**
  - start -> RUN
  - clr -> IDLE, with a cnt_clear pulse
  - lap is ignored
- **Prescaler.** A counter running 0..CLK_DIV-1.
  - It advances only in RUN and LAP, and holds its value in PAUSE so the sub-tick phase is preserved.
  - It is forced to 0 in IDLE and whenever cnt_clear is asserted.
  - cnt_tick = 1 when the prescaler equals CLK_DIV-1 and the state is RUN or LAP. The prescaler wraps to 0 on that cycle.
- **Display.** disp_value is a register.
  - In LAP it holds the lap register.
  - In all other states it loads cnt_value every cycle, giving 1 cycle of latency.
- **Overflow.** overflow is set when cnt_carry_top = 1 in RUN or LAP. It is cleared only by a cnt_clear pulse. The counter chain simply wraps and the watch keeps running.
- **Output flags.** running and lap_active are decoded from the state register.

## Timing
- **Reset values.** All outputs are 0; state = IDLE; prescaler = 0; debounced levels = 0; lap register = 0.
- **Button latency.** The raw rising edge is first sampled at cycle 0. With the line held high throughout, the press pulse is high in cycle DEB_CYCLES+2 and the state register updates in cycle DEB_CYCLES+3.
- **Pulse alignment.** cnt_clear is high in the same cycle the state register enters IDLE from the clr event, i.e. the cycle after the press pulse. It lasts exactly one cycle.
- **First tick.** The first cnt_tick after entering RUN from IDLE occurs CLK_DIV cycles after the state becomes RUN. The cycle in which the state becomes RUN counts as prescaler value 0.
- **Pause/resume.** Ticks never occur in PAUSE. After resume, the remaining count before the next tick equals the count remaining at the moment of pause.
- **Lap latch.** The lap register captures cnt_value in the cycle of the lap press pulse. disp_value shows the frozen value from the next cycle onward.
- **Mid-operation reset.** Asserting rst_n low at any time asynchronously returns every register to its reset value. No cnt_clear is emitted; the counters have their own rst_n.

## Test plan
Benches use CLK_DIV=4 and DEB_CYCLES=3.
- **Start and tick timing:** reset, then press start (hold 10 cycles) -> running=1 in cycle 6 after the raw edge; cnt_tick pulses every 4 cycles, the first 4 cycles after running rises.
- **Pause phase and clear:** run for 2 cycles past a tick, then press start -> PAUSE with no ticks; press start again -> the next tick comes 2 cycles after RUN is re-entered; from PAUSE press clr -> one cnt_clear pulse, state IDLE, prescaler 0.
- **Lap freeze:** with cnt_value=24'h000123, press lap -> disp_value stays 24'h000123 while cnt_value changes and lap_active=1; press lap again -> disp_value follows cnt_value with 1 cycle of delay.
- **Bounce rejection:** in IDLE, toggle btn_start high/low every 2 cycles for 20 cycles -> no event, state stays IDLE; then hold high -> exactly one start event.
- **Simultaneous presses:** in PAUSE, press clr and start in the same cycle -> IDLE with cnt_clear; in RUN, press clr -> ignored, state stays RUN.
- **Overflow and reset:** in RUN, pulse cnt_carry_top -> overflow=1 and it persists through PAUSE; clr clears it; assert rst_n low in LAP -> all outputs 0 immediately.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button front end, watch FSM,
// count-tick prescaler and lap/display register.
module stopwatch_ctrl #(
  parameter int CLK_DIV    = 100000,
  parameter int DEB_CYCLES = 200000,
  parameter int DIGITS     = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_start,
  input  logic                btn_lap,
  input  logic                btn_clr,
  input  logic [4*DIGITS-1:0] cnt_value,
  input  logic                cnt_carry_top,
  output logic                cnt_tick,
  output logic                cnt_clear,
  output logic [4*DIGITS-1:0] disp_value,
  output logic                running,
  output logic                lap_active,
  output logic                overflow
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam int B_START = 0;
  localparam int B_LAP   = 1;
  localparam int B_CLR   = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAP,
    PAUSE
  } state_e;

  logic [2:0]          raw;
  logic [2:0]          sync1_q;
  logic [2:0]          sync2_q;
  logic [2:0]          lvl_q;
  logic [2:0]          lvl_d;
  logic [2:0]          lvl_old_q;
  logic [2:0]          press_q;
  logic [2:0]          press_d;
  logic [DW-1:0]       dcnt_q [3];
  logic [DW-1:0]       dcnt_d [3];
  state_e              state_q;
  state_e              state_d;
  logic                clear_q;
  logic                clear_d;
  logic                lap_ld;
  logic                ev_clr;
  logic                ev_start;
  logic                ev_lap;
  logic                run_st;
  logic [PW-1:0]       pre_q;
  logic [PW-1:0]       pre_d;
  logic [4*DIGITS-1:0] lap_q;
  logic [4*DIGITS-1:0] lap_d;
  logic [4*DIGITS-1:0] disp_q;
  logic [4*DIGITS-1:0] disp_d;
  logic                ovf_q;
  logic                ovf_d;

  assign raw = {btn_clr, btn_lap, btn_start};

  // Debounce: flip level after DEB_CYCLES differing samples.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      lvl_d[i]  = lvl_q[i];
      dcnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
    press_d = lvl_q & ~lvl_old_q;
  end

  // Button front-end registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      lvl_old_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        dcnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      lvl_old_q <= lvl_q;
      press_q   <= press_d;
      for (int i = 0; i < 3; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  assign ev_clr   = press_q[B_CLR];
  assign ev_start = press_q[B_START] & ~press_q[B_CLR];
  assign ev_lap   = press_q[B_LAP] & ~press_q[B_START]
                  & ~press_q[B_CLR];

  // Watch FSM: next state, clear request, lap load.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    lap_ld  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ev_clr) begin
          clear_d = 1'b1;
        end else if (ev_start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ev_start) begin
          state_d = PAUSE;
        end else if (ev_lap) begin
          state_d = LAP;
          lap_ld  = 1'b1;
        end
      end
      LAP: begin
        if (ev_start) begin
          state_d = PAUSE;
        end else if (ev_lap) begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (ev_clr) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (ev_start) begin
          state_d = RUN;
        end
      end
    endcase
  end

  assign run_st   = (state_q == RUN) || (state_q == LAP);
  assign cnt_tick = run_st && (pre_q == PRE_LAST);

  // Prescaler, lap/display and overflow next values.
  always_comb begin
    pre_d = pre_q;
    if ((state_q == IDLE) || clear_q) begin
      pre_d = '0;
    end else if (cnt_tick) begin
      pre_d = '0;
    end else if (run_st) begin
      pre_d = pre_q + PW'(1);
    end
    lap_d  = lap_ld ? cnt_value : lap_q;
    disp_d = (state_q == LAP) ? lap_q : cnt_value;
    ovf_d  = clear_q ? 1'b0 : (ovf_q | (cnt_carry_top & run_st));
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      clear_q <= 1'b0;
      pre_q   <= '0;
      lap_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_q <= clear_d;
      pre_q   <= pre_d;
      lap_q   <= lap_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cnt_clear  = clear_q;
  assign disp_value = disp_q;
  assign running    = run_st;
  assign lap_active = (state_q == LAP);
  assign overflow   = ovf_q;

endmodule
